spi_sender_shifter: RTL

//  Transmit datapath of the SPI interface, directly downstream of the control combination block.

---
 rtl/spi_sender_shifter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_sender_shifter.sv
// SPI mode-0 transmit shifter: holds one word from the sender buffer and serialises it MSB-first,
// either as master (generating SCK/SS_N) or as slave (following a synchronised external SCK/SS_N).
`timescale 1ns/1ps
module spi_sender_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  SH_LD,
    input  logic                  SENDER_WRITE,
    input  logic                  TE,
    input  logic                  MS_MODE,
    input  logic                  SCK_IN,
    input  logic                  SS_N_IN,
    output logic                  SDO,
    output logic                  SCK_OUT,
    output logic                  SS_N_OUT,
    output logic                  EMPTY_STATE,
    output logic                  BUSY,
    output logic                  ABORT
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        M_SHIFT,
        DONE,
        ARMED,
        S_SHIFT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            sck_sync;
    logic [2:0]            ss_sync;
    logic                  div_tick;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  ss_rise;

    // [0],[1] form the 2-FF synchroniser; [2] is the edge-detect reference
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sck_sync <= '0;
            ss_sync  <= '1;
        end else begin
            sck_sync <= {sck_sync[1:0], SCK_IN};
            ss_sync  <= {ss_sync[1:0], SS_N_IN};
        end
    end

    always_comb begin
        div_tick = (div_cnt == DIV_LAST);
        sck_rise = sck_sync[1] & ~sck_sync[2];
        sck_fall = ~sck_sync[1] & sck_sync[2];
        ss_rise  = ss_sync[1] & ~ss_sync[2];
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state       <= IDLE;
            hold        <= '0;
            hold_valid  <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            SDO         <= 1'b0;
            SCK_OUT     <= 1'b0;
            SS_N_OUT    <= 1'b1;
            EMPTY_STATE <= 1'b1;
            BUSY        <= 1'b0;
            ABORT       <= 1'b0;
        end else begin
            ABORT <= 1'b0;
            case (state)
                IDLE: begin
                    if (SENDER_WRITE && TE && hold_valid) begin
                        shreg       <= hold;
                        hold_valid  <= 1'b0;
                        EMPTY_STATE <= 1'b0;
                        BUSY        <= 1'b1;
                        SDO         <= hold[DATA_WIDTH-1];
                        bit_cnt     <= '0;
                        div_cnt     <= '0;
                        if (MS_MODE) begin
                            SS_N_OUT <= 1'b0;
                            state    <= SETUP;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                SETUP: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        SCK_OUT <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= M_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                M_SHIFT: begin
                    // the final low half-period runs out here before DONE, giving 2*W+2 half-periods of SS_N low
                    if (div_tick) begin
                        div_cnt <= '0;
                        if (SCK_OUT) begin
                            SCK_OUT <= 1'b0;
                            shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            SDO     <= shreg[DATA_WIDTH-2];
                        end else if (bit_cnt == BIT_LAST) begin
                            state <= DONE;
                        end else begin
                            SCK_OUT <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (div_tick) begin
                        div_cnt     <= '0;
                        SS_N_OUT    <= 1'b1;
                        EMPTY_STATE <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ARMED: begin
                    if (!ss_sync[1]) state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ss_rise && (bit_cnt < BIT_LAST)) begin
                        ABORT       <= 1'b1;
                        EMPTY_STATE <= 1'b1;
                        BUSY        <= 1'b0;
                        shreg       <= '0;
                        state       <= IDLE;
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST - 1'b1) begin
                            EMPTY_STATE <= 1'b1;
                            BUSY        <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (sck_fall) begin
                        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                        SDO   <= shreg[DATA_WIDTH-2];
                    end
                end
                default: state <= IDLE;
            endcase
            if (SH_LD) begin
                hold       <= DATA_IN;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule
